// File: rtl/data_sram_responder.sv
// data_sram_responder: word-organised data RAM answering SRAM-like requests in order after DATA_LAT cycles,
// with at most QDEPTH outstanding responses and an optional addr_ok gap after each accept.
module data_sram_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int DATA_LAT  = 2,
    parameter int QDEPTH    = 2,
    parameter int ADDR_GAP  = 0
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      data_sram_req,
    input  logic                      data_sram_wr,
    input  logic [1:0]                data_sram_size,
    input  logic [3:0]                data_sram_wstrb,
    input  logic [31:0]               data_sram_addr,
    input  logic [31:0]               data_sram_wdata,
    output logic                      data_sram_addr_ok,
    output logic                      data_sram_data_ok,
    output logic [31:0]               data_sram_rdata,
    output logic [$clog2(QDEPTH):0]   outstanding
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int TW = $clog2(DATA_LAT + 1);
    localparam int GW = $clog2(ADDR_GAP + 2);
    localparam int PW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [31:0]       mem [MEM_WORDS];
    logic [31:0]       q_data [QDEPTH];
    logic [TW-1:0]     q_timer [QDEPTH];
    logic [QDEPTH-1:0] q_valid;
    logic [PW-1:0]     rptr, wptr;
    logic [CW-1:0]     count;
    logic [GW-1:0]     gap_cnt;
    logic              accept, pop;
    logic [3:0]        lane_mask;
    logic [AW-1:0]     idx;
    logic              unused_addr;

    assign idx = data_sram_addr[AW+1:2];
    assign unused_addr = ^data_sram_addr[31:AW+2];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(QDEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        lane_mask = data_sram_wstrb & (data_sram_size == 2'd0 ? 4'b0001 << data_sram_addr[1:0] :
                                       data_sram_size == 2'd1 ? (data_sram_addr[1] ? 4'b1100 : 4'b0011) :
                                       data_sram_size == 2'd2 ? 4'b1111 : 4'b0000);
        // count is the pre-pop occupancy: a full queue never accepts in its pop cycle
        data_sram_addr_ok = resetn && count < CW'(QDEPTH) && gap_cnt == '0;
        accept = data_sram_req && data_sram_addr_ok;
        pop = q_valid[rptr] && q_timer[rptr] == '0;
        data_sram_data_ok = pop;
        data_sram_rdata = pop ? q_data[rptr] : '0;
        outstanding = count;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count   <= '0;
            gap_cnt <= '0;
            q_valid <= '0;
            rptr    <= '0;
            wptr    <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_timer[i] <= '0;
                q_data[i]  <= '0;
            end
        end else begin
            count   <= count + CW'(accept) - CW'(pop);
            gap_cnt <= accept ? GW'(ADDR_GAP) : gap_cnt != '0 ? gap_cnt - 1'b1 : '0;
            for (int i = 0; i < QDEPTH; i++)
                if (q_timer[i] != '0) q_timer[i] <= q_timer[i] - 1'b1;
            if (pop) begin
                q_valid[rptr] <= 1'b0;
                rptr          <= nxt(rptr);
            end
            if (accept) begin
                q_valid[wptr] <= 1'b1;
                q_timer[wptr] <= TW'(DATA_LAT - 1);
                q_data[wptr]  <= data_sram_wr ? '0 : mem[idx];
                wptr          <= nxt(wptr);
            end
        end
    end

    // RAM is deliberately not reset; accept already implies resetn high
    always_ff @(posedge clk) begin
        if (accept && data_sram_wr)
            for (int b = 0; b < 4; b++)
                if (lane_mask[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: three responder configurations driven by vector tables, directed
// multi-cycle sequences and randomized traffic checked against a response-schedule model.
module tb_data_sram_responder;
    logic        clk = 1'b0;
    logic        rstn [3];
    logic        req [3], wr [3];
    logic [1:0]  sz [3];
    logic [3:0]  st [3];
    logic [31:0] ad [3], wd [3];
    logic        aok [3], dok [3];
    logic [31:0] rd [3];
    logic [3:0]  outw [3];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = g == 0 ? 1 : g == 1 ? 3 : 2;
        localparam int Q = g == 2 ? 3 : 2;
        localparam int G = g == 2 ? 2 : 0;
        logic [$clog2(Q):0] o;
        data_sram_responder #(.MEM_WORDS(1024), .DATA_LAT(L), .QDEPTH(Q), .ADDR_GAP(G)) u (
            .clk(clk), .resetn(rstn[g]),
            .data_sram_req(req[g]), .data_sram_wr(wr[g]), .data_sram_size(sz[g]),
            .data_sram_wstrb(st[g]), .data_sram_addr(ad[g]), .data_sram_wdata(wd[g]),
            .data_sram_addr_ok(aok[g]), .data_sram_data_ok(dok[g]), .data_sram_rdata(rd[g]),
            .outstanding(o)
        );
        assign outw[g] = 4'(o);
    end

    function automatic int lat_of(int k); return k == 0 ? 1 : k == 1 ? 3 : 2; endfunction
    function automatic int qd_of(int k);  return k == 2 ? 3 : 2; endfunction
    function automatic int gap_of(int k); return k == 2 ? 2 : 0; endfunction

    function automatic bit lane_hit(logic [1:0] s, logic [1:0] lo, int b);
        return s == 2'd0 ? b == int'(lo) : s == 2'd1 ? (b / 2) == int'(lo[1]) : s == 2'd2;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(int k, bit r, bit w, logic [1:0] s, logic [3:0] t, logic [31:0] a,
                        logic [31:0] d, bit eok, bit edok, logic [31:0] erd, int eout, string nm);
        @(negedge clk);
        req[k] = r; wr[k] = w; sz[k] = s; st[k] = t; ad[k] = a; wd[k] = d;
        #1;
        chk({nm, "/addr_ok"}, 32'(aok[k]), 32'(eok));
        chk({nm, "/data_ok"}, 32'(dok[k]), 32'(edok));
        chk({nm, "/outstanding"}, 32'(outw[k]), 32'(eout));
        if (edok) chk({nm, "/rdata"}, rd[k], erd);
    endtask

    task automatic rst_pulse(int k);
        @(negedge clk);
        req[k] = 1'b0; rstn[k] = 1'b0;
        #1;
        chk("rst/outstanding", 32'(outw[k]), 0);
        chk("rst/data_ok", 32'(dok[k]), 0);
        chk("rst/addr_ok", 32'(aok[k]), 0);
        @(negedge clk);
        rstn[k] = 1'b1;
    endtask

    typedef struct { int due; logic [31:0] d; } resp_t;

    task automatic rnd(int k, int n);
        resp_t q[$];
        logic [31:0] mm [8];
        int last = -100, init = 0;
        for (int c = 0; c < n; c++) begin
            bit r, w, eok, edok;
            logic [1:0] s;
            logic [3:0] t;
            logic [2:0] wi;
            logic [31:0] a, d;
            resp_t e;
            @(negedge clk);
            if (init < 8) begin
                r = 1; w = 1; s = 2'd2; t = 4'hF; wi = init[2:0];
            end else begin
                r = ($urandom % 4) != 0; w = 1'($urandom); s = 2'($urandom);
                t = 4'($urandom); wi = 3'($urandom);
            end
            d = $urandom;
            a = $urandom;
            a[11:5] = '0;
            a[4:2] = wi;
            req[k] = r; wr[k] = w; sz[k] = s; st[k] = t; ad[k] = a; wd[k] = d;
            #1;
            eok  = q.size() < qd_of(k) && c - last > gap_of(k);
            edok = q.size() > 0 && q[0].due <= c;
            chk("rnd/addr_ok", 32'(aok[k]), 32'(eok));
            chk("rnd/data_ok", 32'(dok[k]), 32'(edok));
            chk("rnd/outstanding", 32'(outw[k]), q.size());
            if (edok) begin
                chk("rnd/rdata", rd[k], q[0].d);
                void'(q.pop_front());
            end
            if (r && eok) begin
                e.due = c + lat_of(k);
                e.d = w ? 32'h0 : mm[wi];
                if (w)
                    for (int b = 0; b < 4; b++)
                        if (t[b] && lane_hit(s, a[1:0], b)) mm[wi][8*b +: 8] = d[8*b +: 8];
                q.push_back(e);
                last = c;
                if (init < 8) init++;
            end
        end
        @(negedge clk);
        req[k] = 1'b0;
    endtask

    typedef struct {
        bit r, w; logic [1:0] s; logic [3:0] t; logic [31:0] a, d;
        bit eok, edok; logic [31:0] erd; int eout;
    } vec_t;

    vec_t tv [15];

    initial begin
        tv[0]  = '{1, 1, 2'd2, 4'hF, 32'h100,      32'hDEADBEEF, 1, 0, 32'h0,        0};
        tv[1]  = '{1, 0, 2'd2, 4'hF, 32'h100,      32'h0,        1, 1, 32'h0,        1};
        tv[2]  = '{1, 1, 2'd2, 4'hF, 32'h104,      32'h11223344, 1, 1, 32'hDEADBEEF, 1};
        tv[3]  = '{1, 1, 2'd0, 4'hF, 32'h106,      32'h00AB0000, 1, 1, 32'h0,        1};
        tv[4]  = '{1, 1, 2'd2, 4'hF, 32'h108,      32'h11223344, 1, 1, 32'h0,        1};
        tv[5]  = '{1, 1, 2'd0, 4'h0, 32'h10A,      32'h00AB0000, 1, 1, 32'h0,        1};
        tv[6]  = '{1, 0, 2'd2, 4'hF, 32'h104,      32'h0,        1, 1, 32'h0,        1};
        tv[7]  = '{1, 0, 2'd2, 4'hF, 32'h108,      32'h0,        1, 1, 32'h11AB3344, 1};
        tv[8]  = '{1, 1, 2'd1, 4'h7, 32'h102,      32'h55660000, 1, 1, 32'h11223344, 1};
        tv[9]  = '{1, 1, 2'd1, 4'hF, 32'h101,      32'h00007788, 1, 1, 32'h0,        1};
        tv[10] = '{1, 0, 2'd2, 4'hF, 32'hFFFFF100, 32'h0,        1, 1, 32'h0,        1};
        tv[11] = '{1, 1, 2'd3, 4'hF, 32'h104,      32'hFFFFFFFF, 1, 1, 32'hDE667788, 1};
        tv[12] = '{1, 0, 2'd2, 4'hF, 32'h104,      32'h0,        1, 1, 32'h0,        1};
        tv[13] = '{0, 0, 2'd0, 4'h0, 32'h0,        32'h0,        1, 1, 32'h11AB3344, 1};
        tv[14] = '{0, 0, 2'd0, 4'h0, 32'h0,        32'h0,        1, 0, 32'h0,        0};

        for (int k = 0; k < 3; k++) begin
            rstn[k] = 1'b0; req[k] = 1'b0; wr[k] = 1'b0; sz[k] = '0;
            st[k] = '0; ad[k] = '0; wd[k] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset/addr_ok", 32'(aok[k]), 0);
            chk("reset/data_ok", 32'(dok[k]), 0);
            chk("reset/outstanding", 32'(outw[k]), 0);
            rstn[k] = 1'b1;
        end

        for (int i = 0; i < 15; i++)
            step(0, tv[i].r, tv[i].w, tv[i].s, tv[i].t, tv[i].a, tv[i].d,
                 tv[i].eok, tv[i].edok, tv[i].erd, tv[i].eout, $sformatf("vec%0d", i));

        // LAT=3, QDEPTH=2 with req held: stalls on a full queue, in-order returns
        step(1, 1, 1, 2'd2, 4'hF, 32'h0, 32'hA0A0A0A0, 1, 0, 0, 0, "l3_w0");
        step(1, 1, 1, 2'd2, 4'hF, 32'h4, 32'hA1A1A1A1, 1, 0, 0, 1, "l3_w1");
        step(1, 1, 1, 2'd2, 4'hF, 32'h8, 32'hA2A2A2A2, 0, 0, 0, 2, "l3_full0");
        step(1, 1, 1, 2'd2, 4'hF, 32'h8, 32'hA2A2A2A2, 0, 1, 0, 2, "l3_full1");
        step(1, 1, 1, 2'd2, 4'hF, 32'h8, 32'hA2A2A2A2, 1, 1, 0, 1, "l3_w2");
        step(1, 1, 0, 2'd2, 4'hF, 32'h0, 32'h0, 1, 0, 0, 1, "l3_r0");
        step(1, 1, 0, 2'd2, 4'hF, 32'h4, 32'h0, 0, 0, 0, 2, "l3_r1a");
        step(1, 1, 0, 2'd2, 4'hF, 32'h4, 32'h0, 0, 1, 0, 2, "l3_r1b");
        step(1, 1, 0, 2'd2, 4'hF, 32'h4, 32'h0, 1, 1, 32'hA0A0A0A0, 1, "l3_r1c");
        step(1, 1, 0, 2'd2, 4'hF, 32'h8, 32'h0, 1, 0, 0, 1, "l3_r2");
        step(1, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 2, "l3_i0");
        step(1, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hA1A1A1A1, 2, "l3_i1");
        step(1, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 1, 1, 32'hA2A2A2A2, 1, "l3_i2");
        step(1, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0, "l3_i3");

        // read accepted while the write to the same word is still awaiting its response
        step(1, 1, 1, 2'd2, 4'hF, 32'h200, 32'hC0FFEE00, 1, 0, 0, 0, "raw_w");
        step(1, 1, 0, 2'd2, 4'hF, 32'h200, 32'h0, 1, 0, 0, 1, "raw_r");
        step(1, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 2, "raw_i0");
        step(1, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 0, 1, 0, 2, "raw_i1");
        step(1, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 1, 1, 32'hC0FFEE00, 1, "raw_i2");
        step(1, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0, "raw_i3");

        // reset with two reads in flight: they must vanish, RAM must survive
        step(1, 1, 0, 2'd2, 4'hF, 32'h0, 32'h0, 1, 0, 0, 0, "mrst_r0");
        step(1, 1, 0, 2'd2, 4'hF, 32'h4, 32'h0, 1, 0, 0, 1, "mrst_r1");
        @(negedge clk);
        req[1] = 1'b0; rstn[1] = 1'b0;
        #1;
        chk("mrst/outstanding", 32'(outw[1]), 0);
        chk("mrst/data_ok", 32'(dok[1]), 0);
        chk("mrst/addr_ok", 32'(aok[1]), 0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("mrst_hold/data_ok", 32'(dok[1]), 0);
        end
        rstn[1] = 1'b1;
        repeat (4) step(1, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0, "mrst_quiet");
        step(1, 1, 0, 2'd2, 4'hF, 32'h200, 32'h0, 1, 0, 0, 0, "mrst_rd");
        step(1, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 1, "mrst_w0");
        step(1, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 1, "mrst_w1");
        step(1, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 1, 1, 32'hC0FFEE00, 1, "mrst_resp");
        step(1, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0, "mrst_done");

        // ADDR_GAP=2 with req held: accepts exactly three cycles apart
        step(2, 1, 1, 2'd2, 4'hF, 32'h0, 32'hB0B0B0B0, 1, 0, 0, 0, "gap_w0");
        step(2, 1, 1, 2'd2, 4'hF, 32'h4, 32'hB1B1B1B1, 0, 0, 0, 1, "gap_a");
        step(2, 1, 1, 2'd2, 4'hF, 32'h4, 32'hB1B1B1B1, 0, 1, 0, 1, "gap_b");
        step(2, 1, 1, 2'd2, 4'hF, 32'h4, 32'hB1B1B1B1, 1, 0, 0, 0, "gap_w1");
        step(2, 1, 0, 2'd2, 4'hF, 32'h0, 32'h0, 0, 0, 0, 1, "gap_c");
        step(2, 1, 0, 2'd2, 4'hF, 32'h0, 32'h0, 0, 1, 0, 1, "gap_d");
        step(2, 1, 0, 2'd2, 4'hF, 32'h0, 32'h0, 1, 0, 0, 0, "gap_r0");
        step(2, 1, 0, 2'd2, 4'hF, 32'h4, 32'h0, 0, 0, 0, 1, "gap_e");
        step(2, 1, 0, 2'd2, 4'hF, 32'h4, 32'h0, 0, 1, 32'hB0B0B0B0, 1, "gap_f");
        step(2, 1, 0, 2'd2, 4'hF, 32'h4, 32'h0, 1, 0, 0, 0, "gap_r1");
        step(2, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 1, "gap_g");
        step(2, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hB1B1B1B1, 1, "gap_h");
        step(2, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0, "gap_i");

        for (int k = 0; k < 3; k++) begin
            rst_pulse(k);
            rnd(k, 400);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
